// File: rtl/scpu_run_ctrl_if.sv
// Debug-side bundle for scpu_run_ctrl: run/step/halt commands, breakpoint and PC in,
// core reset/enable, status flags and counters out.
interface scpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             cmd_run;
  logic             cmd_halt;
  logic             cmd_step;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc_in;
  logic             cpu_rst;
  logic             cpu_ce;
  logic             halted;
  logic [1:0]       state;
  logic             bp_hit;
  logic             loop_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output cmd_run, cmd_halt, cmd_step, bp_en, bp_addr, pc_in,
    input  cpu_rst, cpu_ce, halted, state, bp_hit, loop_hit, cycle_cnt, retire_cnt
  );

  modport slave (
    input  cmd_run, cmd_halt, cmd_step, bp_en, bp_addr, pc_in,
    output cpu_rst, cpu_ce, halted, state, bp_hit, loop_hit, cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/scpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle core: owns core reset, clock enable,
// PC breakpoint and cycle/retire counters. Optional self-loop halt: SCPU_RUNCTRL_LOOP_DET_EN.
module scpu_run_ctrl #(
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  scpu_run_ctrl_if.slave ctrl
);
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              halted_q, halted_d;
  logic              skip_q, skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic              loop_hit_q, loop_hit_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              match_c;
  logic              ce_c;
  logic              loop_c;

  assign match_c = ctrl.bp_en && (ctrl.pc_in == ctrl.bp_addr) && !skip_q;

  // Core enable: decoded from registered state, gated same-cycle by halt and breakpoint.
  always_comb begin
    ce_c = 1'b0;
    case (state_q)
      S_STEP:  ce_c = !ctrl.cmd_halt;
      S_RUN:   ce_c = !match_c && !ctrl.cmd_halt;
      default: ce_c = 1'b0;
    endcase
  end

`ifdef SCPU_RUNCTRL_LOOP_DET_EN
  logic [31:0] last_pc_q, last_pc_d;
  logic        lpv_q, lpv_d;
  logic        clr_lpv_c;

  // Leaving HALT means entering RUN or STEP; forget the previous PC then.
  assign clr_lpv_c = (state_q == S_HALT) && (state_d != S_HALT);
  assign loop_c    = (state_q == S_RUN) && ce_c && lpv_q && (ctrl.pc_in == last_pc_q);

  always_comb begin
    last_pc_d = last_pc_q;
    lpv_d     = lpv_q;
    if (clr_lpv_c) begin
      lpv_d = 1'b0;
    end else if (ce_c) begin
      last_pc_d = ctrl.pc_in;
      lpv_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc_q <= 32'd0;
      lpv_q     <= 1'b0;
    end else begin
      last_pc_q <= last_pc_d;
      lpv_q     <= lpv_d;
    end
  end
`else
  assign loop_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cpu_rst_d  = cpu_rst_q;
    skip_d     = skip_q;
    bp_hit_d   = bp_hit_q;
    loop_hit_d = loop_hit_q;
    case (state_q)
      S_HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) begin
          state_d   = S_HALT;
          cpu_rst_d = 1'b0;
        end
      end
      S_HALT: begin
        if (ctrl.cmd_halt) begin
          state_d = S_HALT;
        end else if (ctrl.cmd_step) begin
          state_d    = S_STEP;
          bp_hit_d   = 1'b0;
          loop_hit_d = 1'b0;
        end else if (ctrl.cmd_run) begin
          state_d    = S_RUN;
          skip_d     = 1'b1;
          bp_hit_d   = 1'b0;
          loop_hit_d = 1'b0;
        end
      end
      S_STEP: state_d = S_HALT;
      S_RUN: begin
        if (match_c) bp_hit_d = 1'b1;
        if (ctrl.cmd_halt || match_c) begin
          state_d = S_HALT;
        end else if (loop_c) begin
          state_d    = S_HALT;
          loop_hit_d = 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase
    // Skip only protects the first instruction after resuming from a breakpoint PC.
    if (ce_c) skip_d = 1'b0;
  end

  assign halted_d = (state_d == S_HALT);
  assign cyc_d    = (state_q != S_HOLD) ? cyc_q + CNT_W'(1) : cyc_q;
  assign ret_d    = ce_c ? ret_q + CNT_W'(1) : ret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_HOLD;
      hold_q     <= HOLD_W'(RST_HOLD);
      cpu_rst_q  <= 1'b1;
      halted_q   <= 1'b0;
      skip_q     <= 1'b0;
      bp_hit_q   <= 1'b0;
      loop_hit_q <= 1'b0;
      cyc_q      <= '0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cpu_rst_q  <= cpu_rst_d;
      halted_q   <= halted_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
      loop_hit_q <= loop_hit_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
    end
  end

  assign ctrl.cpu_rst    = cpu_rst_q;
  assign ctrl.cpu_ce     = ce_c;
  assign ctrl.halted     = halted_q;
  assign ctrl.state      = state_q;
  assign ctrl.bp_hit     = bp_hit_q;
  assign ctrl.loop_hit   = loop_hit_q;
  assign ctrl.cycle_cnt  = cyc_q;
  assign ctrl.retire_cnt = ret_q;
endmodule

// File: tb/tb_scpu_run_ctrl.sv
// Self-checking bench for scpu_run_ctrl: randomized run/step/breakpoint scenarios checked
// against expectations derived from instruction and clock counting.
module tb_scpu_run_ctrl;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned CNT_W    = 32;

  logic clk;
  logic reset;
  int   errs;
  int   checks;
  int unsigned exp_cyc;
  int unsigned exp_ret;
  bit   live;
  logic [31:0] pc_q;
  bit   freeze;
  bit   load_en;
  logic [31:0] load_val;

  scpu_run_ctrl_if #(.CNT_W(CNT_W)) ctrl ();

  scpu_run_ctrl #(.RST_HOLD(RST_HOLD), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .ctrl (ctrl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core: PC advances by one instruction on every enabled clock.
  always @(posedge clk or negedge reset) begin
    if (!reset)              pc_q <= 32'd0;
    else if (load_en)        pc_q <= load_val;
    else if (ctrl.cpu_rst)   pc_q <= 32'd0;
    else if (ctrl.cpu_ce && !freeze) pc_q <= pc_q + 32'd4;
  end
  assign ctrl.pc_in = pc_q;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    if (live) exp_cyc++;
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    load_en = 1'b1; load_val = v;
    tick();
    load_en = 1'b0;
  endtask

  task automatic release_reset();
    live = 1'b0; exp_cyc = 0; exp_ret = 0;
    #3;
    checks++; if (ctrl.state !== 2'd0) begin errs++; $display("FAIL rst_state got=%0d exp=0", ctrl.state); end
    checks++; if (ctrl.cpu_rst !== 1'b1) begin errs++; $display("FAIL rst_cpu_rst got=%b exp=1", ctrl.cpu_rst); end
    checks++; if (ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL rst_cpu_ce got=%b exp=0", ctrl.cpu_ce); end
    checks++; if (ctrl.cycle_cnt !== '0 || ctrl.retire_cnt !== '0) begin errs++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", ctrl.cycle_cnt, ctrl.retire_cnt); end
    checks++; if (ctrl.bp_hit !== 1'b0 || ctrl.loop_hit !== 1'b0 || ctrl.halted !== 1'b0) begin errs++; $display("FAIL rst_flags got=%b%b%b exp=000", ctrl.bp_hit, ctrl.loop_hit, ctrl.halted); end
    @(posedge clk); #1;
    reset = 1'b1;
    ctrl.cmd_run = 1'b1;
    for (int k = 0; k < int'(RST_HOLD); k++) begin
      @(negedge clk);
      checks++; if (ctrl.cpu_rst !== 1'b1 || ctrl.state !== 2'd0) begin errs++; $display("FAIL hold_%0d got=rst%b st%0d exp=rst1 st0", k, ctrl.cpu_rst, ctrl.state); end
      tick();
    end
    ctrl.cmd_run = 1'b0;
    checks++; if (ctrl.cpu_rst !== 1'b0) begin errs++; $display("FAIL hold_end_rst got=%b exp=0", ctrl.cpu_rst); end
    checks++; if (ctrl.state !== 2'd1 || ctrl.halted !== 1'b1) begin errs++; $display("FAIL hold_end_state got=%0d/%b exp=1/1", ctrl.state, ctrl.halted); end
    checks++; if (ctrl.cpu_ce !== 1'b0 || ctrl.cycle_cnt !== '0) begin errs++; $display("FAIL hold_end_ce_cyc got=%b/%0d exp=0/0", ctrl.cpu_ce, ctrl.cycle_cnt); end
    live = 1'b1;
    tick();
    checks++; if (ctrl.cycle_cnt !== CNT_W'(exp_cyc)) begin errs++; $display("FAIL first_cycle_cnt got=%0d exp=%0d", ctrl.cycle_cnt, exp_cyc); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    release_reset();
  endtask

  task automatic test_step();
    for (int s = 0; s < 3; s++) begin
      ctrl.cmd_step = 1'b1;
      @(negedge clk);
      checks++; if (ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL step_halt_ce got=%b exp=0", ctrl.cpu_ce); end
      tick();
      ctrl.cmd_step = 1'b0;
      @(negedge clk);
      checks++; if (ctrl.state !== 2'd3 || ctrl.cpu_ce !== 1'b1) begin errs++; $display("FAIL step_active got=st%0d ce%b exp=st3 ce1", ctrl.state, ctrl.cpu_ce); end
      tick(); exp_ret++;
      checks++; if (ctrl.state !== 2'd1) begin errs++; $display("FAIL step_return got=%0d exp=1", ctrl.state); end
      repeat ($urandom_range(2, 6)) tick();
    end
    // Halt during the step cycle suppresses the retire.
    ctrl.cmd_step = 1'b1; tick(); ctrl.cmd_step = 1'b0;
    ctrl.cmd_halt = 1'b1;
    @(negedge clk);
    checks++; if (ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL step_gated_ce got=%b exp=0", ctrl.cpu_ce); end
    tick(); ctrl.cmd_halt = 1'b0;
    checks++; if (ctrl.state !== 2'd1) begin errs++; $display("FAIL step_gated_state got=%0d exp=1", ctrl.state); end
    checks++; if (ctrl.retire_cnt !== CNT_W'(exp_ret) || ctrl.cycle_cnt !== CNT_W'(exp_cyc)) begin errs++; $display("FAIL step_counts got=%0d/%0d exp=%0d/%0d", ctrl.retire_cnt, ctrl.cycle_cnt, exp_ret, exp_cyc); end
  endtask

  task automatic test_breakpoint();
    int unsigned k;
    k = $urandom_range(2, 8);
    load_pc(32'd0);
    ctrl.bp_en = 1'b1; ctrl.bp_addr = 32'(4 * k);
    ctrl.cmd_run = 1'b1; tick(); ctrl.cmd_run = 1'b0;
    for (int unsigned i = 0; i < k; i++) begin
      @(negedge clk);
      checks++; if (ctrl.cpu_ce !== 1'b1) begin errs++; $display("FAIL bp_pre_ce pc=%h got=%b exp=1", pc_q, ctrl.cpu_ce); end
      tick(); exp_ret++;
    end
    @(negedge clk);
    checks++; if (ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL bp_gate_ce pc=%h got=%b exp=0", pc_q, ctrl.cpu_ce); end
    tick();
    checks++; if (ctrl.state !== 2'd1 || ctrl.bp_hit !== 1'b1) begin errs++; $display("FAIL bp_stop got=st%0d hit%b exp=st1 hit1", ctrl.state, ctrl.bp_hit); end
    checks++; if (ctrl.retire_cnt !== CNT_W'(exp_ret)) begin errs++; $display("FAIL bp_retire got=%0d exp=%0d", ctrl.retire_cnt, exp_ret); end
    ctrl.cmd_run = 1'b1; tick(); ctrl.cmd_run = 1'b0;
    checks++; if (ctrl.bp_hit !== 1'b0 || ctrl.state !== 2'd2) begin errs++; $display("FAIL bp_resume got=hit%b st%0d exp=hit0 st2", ctrl.bp_hit, ctrl.state); end
    @(negedge clk);
    checks++; if (ctrl.cpu_ce !== 1'b1) begin errs++; $display("FAIL bp_skip_ce got=%b exp=1", ctrl.cpu_ce); end
    tick(); exp_ret++;
    ctrl.cmd_halt = 1'b1;
    @(negedge clk);
    checks++; if (ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL run_halt_ce got=%b exp=0", ctrl.cpu_ce); end
    tick(); ctrl.cmd_halt = 1'b0;
    checks++; if (ctrl.state !== 2'd1 || ctrl.retire_cnt !== CNT_W'(exp_ret)) begin errs++; $display("FAIL bp_end got=st%0d ret%0d exp=st1 ret%0d", ctrl.state, ctrl.retire_cnt, exp_ret); end
    ctrl.bp_en = 1'b0;
  endtask

  task automatic test_bp_live();
    load_pc(32'($urandom_range(0, 255)) << 2);
    ctrl.cmd_run = 1'b1; tick(); ctrl.cmd_run = 1'b0;
    repeat ($urandom_range(1, 4)) begin tick(); exp_ret++; end
    ctrl.bp_addr = pc_q; ctrl.bp_en = 1'b1;
    @(negedge clk);
    checks++; if (ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL bp_live_ce got=%b exp=0", ctrl.cpu_ce); end
    tick(); ctrl.bp_en = 1'b0;
    checks++; if (ctrl.state !== 2'd1 || ctrl.bp_hit !== 1'b1 || ctrl.retire_cnt !== CNT_W'(exp_ret)) begin errs++; $display("FAIL bp_live_stop got=st%0d hit%b ret%0d exp=st1 hit1 ret%0d", ctrl.state, ctrl.bp_hit, ctrl.retire_cnt, exp_ret); end
  endtask

  task automatic test_cmd_priority();
    ctrl.cmd_run = 1'b1; tick(); ctrl.cmd_run = 1'b0;
    repeat ($urandom_range(1, 5)) begin tick(); exp_ret++; end
    ctrl.cmd_halt = 1'b1; ctrl.cmd_step = 1'b1; ctrl.cmd_run = 1'b1;
    @(negedge clk);
    checks++; if (ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL prio_run_ce got=%b exp=0", ctrl.cpu_ce); end
    tick();
    checks++; if (ctrl.state !== 2'd1 || ctrl.retire_cnt !== CNT_W'(exp_ret)) begin errs++; $display("FAIL prio_run_stop got=st%0d ret%0d exp=st1 ret%0d", ctrl.state, ctrl.retire_cnt, exp_ret); end
    tick();
    checks++; if (ctrl.state !== 2'd1 || ctrl.cpu_ce !== 1'b0) begin errs++; $display("FAIL prio_halt_wins got=st%0d ce%b exp=st1 ce0", ctrl.state, ctrl.cpu_ce); end
    ctrl.cmd_halt = 1'b0; ctrl.cmd_run = 1'b0;
    tick();
    checks++; if (ctrl.state !== 2'd3) begin errs++; $display("FAIL prio_step_over_run got=%0d exp=3", ctrl.state); end
    ctrl.cmd_step = 1'b0;
    tick(); exp_ret++;
    checks++; if (ctrl.retire_cnt !== CNT_W'(exp_ret)) begin errs++; $display("FAIL prio_retire got=%0d exp=%0d", ctrl.retire_cnt, exp_ret); end
  endtask

  task automatic test_reset_midrun();
    ctrl.cmd_run = 1'b1; tick(); ctrl.cmd_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (ctrl.cpu_ce !== 1'b1) begin errs++; $display("FAIL midrun_ce_%0d got=%b exp=1", i, ctrl.cpu_ce); end
      tick(); exp_ret++;
    end
    checks++; if (ctrl.retire_cnt !== CNT_W'(exp_ret) || ctrl.cycle_cnt !== CNT_W'(exp_cyc)) begin errs++; $display("FAIL midrun_counts got=%0d/%0d exp=%0d/%0d", ctrl.retire_cnt, ctrl.cycle_cnt, exp_ret, exp_cyc); end
    #2; reset = 1'b0; #1;
    checks++; if (ctrl.cpu_ce !== 1'b0 || ctrl.cpu_rst !== 1'b1 || ctrl.state !== 2'd0) begin errs++; $display("FAIL midrun_async got=ce%b rst%b st%0d exp=ce0 rst1 st0", ctrl.cpu_ce, ctrl.cpu_rst, ctrl.state); end
    release_reset();
  endtask

  task automatic test_loop();
    load_pc(32'h0000_0024);
    freeze = 1'b1;
    ctrl.cmd_run = 1'b1; tick(); ctrl.cmd_run = 1'b0;
`ifdef SCPU_RUNCTRL_LOOP_DET_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ctrl.cpu_ce !== 1'b1) begin errs++; $display("FAIL loop_ce_%0d got=%b exp=1", i, ctrl.cpu_ce); end
      tick(); exp_ret++;
    end
    checks++; if (ctrl.halted !== 1'b1 || ctrl.loop_hit !== 1'b1) begin errs++; $display("FAIL loop_stop got=halt%b loop%b exp=1/1", ctrl.halted, ctrl.loop_hit); end
`else
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (ctrl.cpu_ce !== 1'b1) begin errs++; $display("FAIL loop_ce_%0d got=%b exp=1", i, ctrl.cpu_ce); end
      tick(); exp_ret++;
    end
    checks++; if (ctrl.state !== 2'd2 || ctrl.loop_hit !== 1'b0) begin errs++; $display("FAIL loop_keeps_running got=st%0d loop%b exp=st2 loop0", ctrl.state, ctrl.loop_hit); end
    ctrl.cmd_halt = 1'b1; tick(); ctrl.cmd_halt = 1'b0;
`endif
    checks++; if (ctrl.retire_cnt !== CNT_W'(exp_ret)) begin errs++; $display("FAIL loop_retire got=%0d exp=%0d", ctrl.retire_cnt, exp_ret); end
    ctrl.cmd_step = 1'b1; tick(); ctrl.cmd_step = 1'b0;
    checks++; if (ctrl.loop_hit !== 1'b0 || ctrl.state !== 2'd3) begin errs++; $display("FAIL loop_clear got=loop%b st%0d exp=loop0 st3", ctrl.loop_hit, ctrl.state); end
    tick(); exp_ret++;
    freeze = 1'b0;
    checks++; if (ctrl.state !== 2'd1 || ctrl.retire_cnt !== CNT_W'(exp_ret)) begin errs++; $display("FAIL loop_step got=st%0d ret%0d exp=st1 ret%0d", ctrl.state, ctrl.retire_cnt, exp_ret); end
  endtask

  initial begin
    errs = 0; checks = 0; exp_cyc = 0; exp_ret = 0; live = 1'b0;
    freeze = 1'b0; load_en = 1'b0; load_val = 32'd0;
    reset = 1'b0;
    ctrl.cmd_run = 1'b0; ctrl.cmd_halt = 1'b0; ctrl.cmd_step = 1'b0;
    ctrl.bp_en = 1'b0; ctrl.bp_addr = 32'd0;
    test_reset();
    test_step();
    test_breakpoint();
    test_bp_live();
    test_cmd_priority();
    test_reset_midrun();
    test_loop();
    checks++; if (ctrl.cycle_cnt !== CNT_W'(exp_cyc)) begin errs++; $display("FAIL final_cycle_cnt got=%0d exp=%0d", ctrl.cycle_cnt, exp_cyc); end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
